// File: rtl/uart_rx_sample_timer_pkg.sv
// Shared types and constants for the UART receive timing path.
// The TX baud generator reuses the prescale constants.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [5:0] PRESC_8  = 6'd8;
    localparam logic [5:0] PRESC_16 = 6'd16;
    localparam logic [5:0] PRESC_32 = 6'd32;

    localparam int MIN_FRAME_BITS = 2;
    localparam int MAX_FRAME_BITS = 15;

endpackage

// File: rtl/uart_prescale_decode.sv
// Combinational decode of an oversampling ratio into legality, terminal edge (P-1)
// and half-bit point (P/2). Shared between the RX sample timer and the TX baud generator.
module uart_prescale_decode
    import uart_rx_pkg::*;
#(
    parameter int EDGE_W = 5
) (
    input  logic [5:0]        prescale,
    output logic              legal,
    output logic [EDGE_W-1:0] terminal,
    output logic [EDGE_W-1:0] half
);

    always_comb begin
        legal    = 1'b0;
        terminal = '0;
        half     = '0;
        case (prescale)
            PRESC_8: begin
                legal    = 1'b1;
                terminal = EDGE_W'(PRESC_8 - 6'd1);
                half     = EDGE_W'(PRESC_8 >> 1);
            end
            PRESC_16: begin
                legal    = 1'b1;
                terminal = EDGE_W'(PRESC_16 - 6'd1);
                half     = EDGE_W'(PRESC_16 >> 1);
            end
            PRESC_32: begin
                legal    = 1'b1;
                terminal = EDGE_W'(PRESC_32 - 6'd1);
                half     = EDGE_W'(PRESC_32 >> 1);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/uart_rx_sample_timer.sv
// Edge/bit timing generator for the UART receiver: one edge counter with a terminal
// count latched at frame start, majority-sample strobes, bit and frame pulses.
module uart_rx_sample_timer
    import uart_rx_pkg::*;
#(
    parameter int MAX_PRESCALE = 32,
    parameter int EDGE_W       = 5,
    parameter int BIT_W        = 4
) (
    input  logic              clk_16,
    input  logic              rst,
    input  logic [5:0]        prescale,
    input  logic [BIT_W-1:0]  frame_bits,
    input  logic              counter_enable,
    output logic [EDGE_W-1:0] edge_count,
    output logic [BIT_W-1:0]  bit_count,
    output logic              sample_strobe,
    output logic              bit_done,
    output logic              frame_done,
    output logic              busy,
    output logic              cfg_err
);

    if (EDGE_W != $clog2(MAX_PRESCALE)) begin : g_bad_edge_w
        $error("EDGE_W must equal clog2(MAX_PRESCALE)");
    end

    localparam logic [31:0] MIN_FB = MIN_FRAME_BITS;
    localparam logic [31:0] MAX_FB = MAX_FRAME_BITS;

    state_t            state_q;
    logic [EDGE_W-1:0] edge_q;
    logic [BIT_W-1:0]  bit_q;
    logic [EDGE_W-1:0] term_q;
    logic [EDGE_W-1:0] half_q;
    logic [BIT_W-1:0]  nlast_q;
    logic              cfg_err_q;

    logic [EDGE_W-1:0] edge_d;
    logic [BIT_W-1:0]  bit_d;
    logic              presc_legal;
    logic [EDGE_W-1:0] presc_term;
    logic [EDGE_W-1:0] presc_half;
    logic [31:0]       fb_ext;
    logic              fb_legal;
    logic              run;
    logic              edge_last;
    logic              bit_last;
    logic [EDGE_W:0]   edge_x;
    logic [EDGE_W:0]   half_x;

    uart_prescale_decode #(
        .EDGE_W (EDGE_W)
    ) u_presc_dec (
        .prescale (prescale),
        .legal    (presc_legal),
        .terminal (presc_term),
        .half     (presc_half)
    );

    assign fb_ext    = 32'(frame_bits);
    assign fb_legal  = (fb_ext >= MIN_FB) && (fb_ext <= MAX_FB);
    assign edge_d    = edge_q + 1'b1;
    assign bit_d     = bit_q + 1'b1;
    assign run       = (state_q == ST_RUN);
    assign edge_last = (edge_q == term_q);
    assign bit_last  = (bit_q == nlast_q);

    always_ff @(posedge clk_16) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            term_q    <= EDGE_W'(PRESC_16 - 6'd1);
            half_q    <= EDGE_W'(PRESC_16 >> 1);
            nlast_q   <= BIT_W'(9);
            cfg_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    edge_q <= '0;
                    bit_q  <= '0;
                    if (counter_enable) begin
                        if (presc_legal && fb_legal) begin
                            term_q  <= presc_term;
                            half_q  <= presc_half;
                            nlast_q <= frame_bits - 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            cfg_err_q <= 1'b1;
                            state_q   <= ST_HOLD;
                        end
                    end
                end
                ST_RUN: begin
                    // An abort outranks a terminal edge in the same cycle.
                    if (!counter_enable) begin
                        state_q <= ST_IDLE;
                        edge_q  <= '0;
                        bit_q   <= '0;
                    end else if (edge_last) begin
                        edge_q <= '0;
                        if (bit_last) begin
                            bit_q   <= '0;
                            state_q <= ST_HOLD;
                        end else begin
                            bit_q <= bit_d;
                        end
                    end else begin
                        edge_q <= edge_d;
                    end
                end
                ST_HOLD: begin
                    edge_q <= '0;
                    bit_q  <= '0;
                    if (!counter_enable) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    edge_q  <= '0;
                    bit_q   <= '0;
                end
            endcase
        end
    end

    // Widened by one bit so half-1 and half+1 never wrap.
    assign edge_x = {1'b0, edge_q};
    assign half_x = {1'b0, half_q};

    assign sample_strobe = run && ((edge_x == half_x - 1'b1) || (edge_x == half_x) ||
                                   (edge_x == half_x + 1'b1));
    assign bit_done      = run && counter_enable && edge_last;
    assign frame_done    = bit_done && bit_last;
    assign busy          = run;
    assign edge_count    = edge_q;
    assign bit_count     = bit_q;
    assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_sample_timer.sv
// Randomized and directed bench for uart_rx_sample_timer against a frame-position model
// (edge = k mod P, bit = k div P for the k-th cycle of a running frame).
module tb_uart_rx_sample_timer;

    logic       clk_16 = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] prescale = 6'd16;
    logic [3:0] frame_bits = 4'd10;
    logic       counter_enable = 1'b0;
    logic [4:0] edge_count;
    logic [3:0] bit_count;
    logic       sample_strobe, bit_done, frame_done, busy, cfg_err;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    int m_mode = 0;
    int m_k    = 0;
    int m_p    = 16;
    int m_n    = 10;
    int m_err  = 0;

    uart_rx_sample_timer dut (
        .clk_16         (clk_16),
        .rst            (rst),
        .prescale       (prescale),
        .frame_bits     (frame_bits),
        .counter_enable (counter_enable),
        .edge_count     (edge_count),
        .bit_count      (bit_count),
        .sample_strobe  (sample_strobe),
        .bit_done       (bit_done),
        .frame_done     (frame_done),
        .busy           (busy),
        .cfg_err        (cfg_err)
    );

    always #5 clk_16 = ~clk_16;

    always @(negedge clk_16) begin : cmp
        int  e_edge, e_bit;
        bit  e_run, e_stb, e_bd, e_fd, legal;
        if (chk_on) begin
            e_run  = (m_mode == 1);
            e_edge = e_run ? (m_k % m_p) : 0;
            e_bit  = e_run ? (m_k / m_p) : 0;
            e_stb  = e_run && (e_edge >= m_p / 2 - 1) && (e_edge <= m_p / 2 + 1);
            e_bd   = e_run && (counter_enable === 1'b1) && (e_edge == m_p - 1);
            e_fd   = e_bd && (e_bit == m_n - 1);
            checks++;
            if (int'(edge_count) != e_edge || int'(bit_count) != e_bit ||
                sample_strobe !== e_stb || bit_done !== e_bd || frame_done !== e_fd ||
                busy !== e_run || int'(cfg_err) != m_err) begin
                errors++;
                $display("FAIL cycle_model t=%0t: got edge=%0d bit=%0d stb=%b bd=%b fd=%b busy=%b err=%b expected edge=%0d bit=%0d stb=%b bd=%b fd=%b busy=%b err=%0d",
                         $time, edge_count, bit_count, sample_strobe, bit_done, frame_done,
                         busy, cfg_err, e_edge, e_bit, e_stb, e_bd, e_fd, e_run, m_err);
            end
            if (!rst) begin
                m_mode = 0; m_k = 0; m_p = 16; m_n = 10; m_err = 0;
            end else begin
                case (m_mode)
                    0: if (counter_enable) begin
                        legal = (prescale == 8 || prescale == 16 || prescale == 32) &&
                                (frame_bits >= 2) && (frame_bits <= 15);
                        if (legal) begin
                            m_p = prescale; m_n = frame_bits; m_k = 0; m_mode = 1;
                        end else begin
                            m_err = 1; m_mode = 2;
                        end
                    end
                    1: begin
                        if (!counter_enable) begin
                            m_mode = 0; m_k = 0;
                        end else if (m_k == m_p * m_n - 1) begin
                            m_mode = 2; m_k = 0;
                        end else begin
                            m_k++;
                        end
                    end
                    default: if (!counter_enable) m_mode = 0;
                endcase
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_16);
            #1;
        end
    endtask

    task automatic wait_pos(input int b, input int e);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_16);
            #1;
            if (busy && int'(bit_count) == b && int'(edge_count) == e) return;
        end
        chk("wait_pos_timeout", 0, 1);
    endtask

    task automatic measure(output int ncyc, output int nbd, output int nstb, output int fst);
        bit seen_fd;
        ncyc = 0; nbd = 0; nstb = 0; fst = -1; seen_fd = 0;
        for (int i = 0; i < 2000 && !seen_fd; i++) begin
            @(negedge clk_16);
            if (busy) ncyc++;
            if (bit_done) nbd++;
            if (sample_strobe) begin
                nstb++;
                if (fst < 0) fst = edge_count;
            end
            if (frame_done) seen_fd = 1;
        end
        chk("frame_done_seen", int'(seen_fd), 1);
    endtask

    task automatic frame(input int p, input int n);
        int c, b, s, f;
        counter_enable = 1'b0;
        cyc(2);
        prescale = 6'(p);
        frame_bits = 4'(n);
        counter_enable = 1'b1;
        measure(c, b, s, f);
        $display("frame P=%0d N=%0d: cycles=%0d bit_done=%0d strobes=%0d first_strobe_edge=%0d", p, n, c, b, s, f);
        chk("frame_cycles", c, p * n);
        chk("bit_done_count", b, n);
        chk("strobe_count", s, 3 * n);
        chk("first_strobe_edge", f, p / 2 - 1);
        cyc(1);
        chk("hold_busy", int'(busy), 0);
    endtask

    function automatic logic [5:0] pick_presc();
        logic [5:0] tbl [10] = '{6'd8, 6'd16, 6'd32, 6'd8, 6'd16, 6'd32, 6'd12, 6'd0, 6'd63, 6'd24};
        return tbl[$urandom_range(0, 9)];
    endfunction

    initial begin
        int c, b, s, f;
        rst = 1'b0;
        @(posedge clk_16);
        #1;
        chk_on = 1'b1;
        cyc(2);
        chk("reset_edge", int'(edge_count), 0);
        chk("reset_bit", int'(bit_count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_cfg_err", int'(cfg_err), 0);
        rst = 1'b1;

        // Basic frame, then HOLD with enable kept high must not restart.
        frame(16, 10);
        cyc(20);
        chk("hold_no_restart_busy", int'(busy), 0);
        chk("hold_no_restart_edge", int'(edge_count), 0);
        frame(8, 11);
        frame(32, 2);

        // Prescale change during a frame is ignored.
        counter_enable = 1'b0;
        cyc(2);
        prescale = 6'd16; frame_bits = 4'd10; counter_enable = 1'b1;
        cyc(1);
        prescale = 6'd8;
        measure(c, b, s, f);
        $display("midframe prescale change: cycles=%0d", c);
        chk("midframe_presc_cycles", c, 160);
        frame(8, 10);

        // Abort at bit 4, edge 9.
        counter_enable = 1'b0;
        cyc(2);
        prescale = 6'd16; frame_bits = 4'd10; counter_enable = 1'b1;
        wait_pos(4, 9);
        counter_enable = 1'b0;
        cyc(1);
        $display("abort: busy=%b edge=%0d bit=%0d", busy, edge_count, bit_count);
        chk("abort_busy", int'(busy), 0);
        chk("abort_edge", int'(edge_count), 0);
        chk("abort_bit", int'(bit_count), 0);
        frame(16, 10);

        // Illegal configurations.
        counter_enable = 1'b0;
        cyc(2);
        prescale = 6'd12; frame_bits = 4'd10; counter_enable = 1'b1;
        cyc(3);
        $display("illegal prescale: cfg_err=%b busy=%b", cfg_err, busy);
        chk("cfg_err_presc", int'(cfg_err), 1);
        chk("cfg_err_presc_busy", int'(busy), 0);
        counter_enable = 1'b0;
        cyc(2);
        prescale = 6'd16; counter_enable = 1'b1;
        cyc(3);
        chk("cfg_err_sticky", int'(cfg_err), 1);
        chk("legal_after_err_busy", int'(busy), 1);
        rst = 1'b0;
        cyc(1);
        chk("cfg_err_cleared", int'(cfg_err), 0);
        rst = 1'b1;
        counter_enable = 1'b0;
        cyc(2);
        frame_bits = 4'd1; counter_enable = 1'b1;
        cyc(3);
        $display("illegal frame_bits: cfg_err=%b busy=%b", cfg_err, busy);
        chk("cfg_err_fb", int'(cfg_err), 1);
        chk("cfg_err_fb_edge", int'(edge_count), 0);

        // Reset mid-frame at bit 3, edge 5.
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        counter_enable = 1'b0;
        cyc(1);
        prescale = 6'd16; frame_bits = 4'd10; counter_enable = 1'b1;
        wait_pos(3, 5);
        rst = 1'b0;
        cyc(1);
        $display("midframe reset: busy=%b edge=%0d bit=%0d", busy, edge_count, bit_count);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_edge", int'(edge_count), 0);
        chk("rst_mid_bit", int'(bit_count), 0);
        rst = 1'b1;

        // Randomized traffic checked by the model every cycle.
        for (int it = 0; it < 80; it++) begin
            int len;
            len = $urandom_range(20, 400);
            prescale = pick_presc();
            frame_bits = 4'($urandom_range(0, 15));
            counter_enable = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < len; k++) begin
                int r;
                @(posedge clk_16);
                #1;
                r = $urandom_range(0, 999);
                rst = 1'b1;
                if (r < 15) counter_enable = ~counter_enable;
                else if (r < 25) prescale = pick_presc();
                else if (r < 30) frame_bits = 4'($urandom_range(0, 15));
                else if (r < 32) rst = 1'b0;
            end
            $display("random segment %0d: len=%0d prescale=%0d frame_bits=%0d en=%b", it, len, prescale, frame_bits, counter_enable);
        end
        rst = 1'b1;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
